// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler for the E stage: owns HI/LO, sequences
// mult/div with fixed latency and requests pipeline stalls while a result is pending.
//
// state | meaning
// IDLE  | no operation in flight; accepts mult/div/mthi/mtlo
// RUN   | counting down a mult/div; pending result is written when cnt hits 0
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        start,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_in_D,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;

    logic               is_long;
    logic               is_mul;
    logic               is_signed;
    logic [63:0]        a_ext;
    logic [63:0]        b_ext;
    logic [63:0]        prod;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign is_long   = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                       (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign is_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);

    assign stall_req = md_in_D & (busy | (start & is_long));

    // Product of sign- or zero-extended operands; low 64 bits are exact either way.
    always_comb begin
        a_ext = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        b_ext = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        prod  = a_ext * b_ext;
    end

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        a_neg = is_signed & rs_val[31];
        b_neg = is_signed & rt_val[31];
        abs_a = a_neg ? (32'd0 - rs_val) : rs_val;
        abs_b = b_neg ? (32'd0 - rt_val) : rt_val;
        uq    = 32'd0;
        ur    = 32'd0;
        if (abs_b != 32'd0) begin
            uq = abs_a / abs_b;
            ur = abs_a % abs_b;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem  = a_neg ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_long) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        if (is_mul) begin
                            cnt     <= CNT_W'(MULT_CYCLES - 1);
                            pend_hi <= prod[63:32];
                            pend_lo <= prod[31:0];
                            pend_wr <= 1'b1;
                        end else begin
                            cnt     <= CNT_W'(DIV_CYCLES - 1);
                            pend_hi <= rem;
                            pend_lo <= quot;
                            pend_wr <= (rt_val != 32'd0);
                        end
                    end else if (start && md_op == OP_MTHI) begin
                        HI <= rs_val;
                    end else if (start && md_op == OP_MTLO) begin
                        LO <= rs_val;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: mult/div results, latency, mt*, stall, reset abort.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op;
    logic        start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_in_D;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .start     (start),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .md_in_D   (md_in_D),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at posedge+1; holds start for one edge, returns at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op  = op;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        md_op  = 3'd0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b stall=%b required 0/0", busy, stall_req);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo HI=%h LO=%h required 0/0", HI, LO);
        end
    endtask

    task automatic test_mult;
        int n;
        logic hold_ok;
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        n = 0;
        hold_ok = 1'b1;
        while (busy === 1'b1 && n < 50) begin
            if (HI !== 32'd0 || LO !== 32'd0) hold_ok = 1'b0;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL mult_latency got %0d required 5", n);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL mult_hold HI/LO changed during busy, required unchanged");
        end
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult_result HI=%h LO=%h required ffffffff/fffffffa", HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        // multu accepted in the first IDLE cycle after the previous mult completed
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        count_busy(n);
        checks++;
        if (n != 5 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            errors++;
            $display("FAIL multu_b2b n=%0d HI=%h LO=%h required 5 fffffffe/00000001", n, HI, LO);
        end
    endtask

    task automatic test_div;
        int n;
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL div_latency got %0d required 10", n);
        end
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg HI=%h LO=%h required ffffffff/fffffffd", HI, LO);
        end
        issue(3'd3, 32'd7, 32'hFFFFFFFE);
        count_busy(n);
        checks++;
        if (HI !== 32'd1 || LO !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_negdivisor HI=%h LO=%h required 00000001/fffffffd", HI, LO);
        end
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        count_busy(n);
        checks++;
        if (HI !== 32'd0 || LO !== 32'h80000000) begin
            errors++;
            $display("FAIL div_overflow HI=%h LO=%h required 00000000/80000000", HI, LO);
        end
        issue(3'd4, 32'hFFFFFFFF, 32'd16);
        count_busy(n);
        checks++;
        if (HI !== 32'h0000000F || LO !== 32'h0FFFFFFF) begin
            errors++;
            $display("FAIL divu HI=%h LO=%h required 0000000f/0fffffff", HI, LO);
        end
    endtask

    task automatic test_mt;
        logic busy_seen;
        busy_seen = 1'b0;
        md_op  = 3'd5;
        rs_val = 32'h1234;
        start  = 1'b1;
        @(posedge clk); #1;
        if (busy !== 1'b0) busy_seen = 1'b1;
        checks++;
        if (HI !== 32'h1234) begin
            errors++;
            $display("FAIL mthi HI=%h required 00001234", HI);
        end
        md_op  = 3'd6;
        rs_val = 32'hABCD;
        @(posedge clk); #1;
        if (busy !== 1'b0) busy_seen = 1'b1;
        start  = 1'b0;
        md_op  = 3'd0;
        checks++;
        if (LO !== 32'hABCD || HI !== 32'h1234) begin
            errors++;
            $display("FAIL mtlo HI=%h LO=%h required 00001234/0000abcd", HI, LO);
        end
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL mt_busy busy went 1 required 0");
        end
    endtask

    task automatic test_divzero;
        int n;
        issue(3'd5, 32'h55, 32'd0);
        issue(3'd6, 32'h55, 32'd0);
        issue(3'd4, 32'd7, 32'd0);
        count_busy(n);
        checks++;
        if (n != 10 || HI !== 32'h55 || LO !== 32'h55) begin
            errors++;
            $display("FAIL divzero n=%0d HI=%h LO=%h required 10 00000055/00000055", n, HI, LO);
        end
    endtask

    task automatic test_stall;
        int n;
        logic any_stall;
        md_in_D = 1'b1;
        md_op   = 3'd1;
        rs_val  = 32'd100;
        rt_val  = 32'd7;
        start   = 1'b1;
        #1;
        n = 0;
        while (stall_req === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
            start = 1'b0;
            md_op = 3'd0;
            #1;
        end
        start = 1'b0;
        md_op = 3'd0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL stall_len got %0d required 6", n);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd700) begin
            errors++;
            $display("FAIL stall_mfhi HI=%h LO=%h required 00000000/000002bc", HI, LO);
        end
        md_in_D = 1'b0;
        @(posedge clk); #1;
        any_stall = 1'b0;
        md_op  = 3'd1;
        rs_val = 32'd3;
        rt_val = 32'd3;
        start  = 1'b1;
        #1;
        if (stall_req !== 1'b0) any_stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            md_op = 3'd0;
            if (stall_req !== 1'b0) any_stall = 1'b1;
        end
        checks++;
        if (any_stall || LO !== 32'd9) begin
            errors++;
            $display("FAIL nostall stall_seen=%b LO=%h required 0 00000009", any_stall, LO);
        end
    endtask

    task automatic test_async_reset;
        int n;
        issue(3'd3, 32'd100, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL async_reset busy=%b HI=%h LO=%h required 0 0/0", busy, HI, LO);
        end
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL post_reset busy=%b HI=%h LO=%h required 0 0/0", busy, HI, LO);
        end
        issue(3'd1, 32'd5, 32'd6);
        count_busy(n);
        checks++;
        if (n != 5 || HI !== 32'd0 || LO !== 32'd30) begin
            errors++;
            $display("FAIL reset_mult n=%0d HI=%h LO=%h required 5 0/0000001e", n, HI, LO);
        end
    endtask

    initial begin
        reset   = 1'b0;
        md_op   = 3'd0;
        start   = 1'b0;
        rs_val  = 32'd0;
        rt_val  = 32'd0;
        md_in_D = 1'b0;
        #12;
        test_reset;
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        test_mult;
        test_back_to_back;
        test_div;
        test_mt;
        test_divzero;
        test_stall;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
